// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: fixed-latency display reads, renderer writes queued into idle cycles.
// Optional double buffering is enabled by defining VGA_FB_DBUF_EN.
module vga_fb_arbiter #(
    parameter int FB_W     = 400,
    parameter int FB_H     = 225,
    parameter int SHIFT    = 2,
    parameter int WQ_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_H_to_be_rendered,
    input  logic [10:0] i_V_to_be_rendered,
    input  logic        i_to_be_rendered_valid,
    input  logic [31:0] i_frame_counter,
    output logic [23:0] o_color,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [8:0]  i_wr_x,
    input  logic [7:0]  i_wr_y,
    input  logic [15:0] i_wr_data,
    input  logic        i_swap_req,
    output logic        o_swap_done,
    output logic        o_front_buf,
    output logic [19:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata
);

    localparam int          AW        = $clog2(WQ_DEPTH);
    localparam logic [19:0] L_FB_W    = 20'(FB_W);
    localparam logic [19:0] L_FB_H    = 20'(FB_H);
    localparam logic [19:0] L_FB_SIZE = 20'(FB_W * FB_H);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t      r_state;
    logic [35:0] r_wq [WQ_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0] r_count;
    logic        r_rd_v2;

    logic [19:0] w_front_base;
    logic [19:0] w_back_base;
    logic [19:0] w_px_x;
    logic [19:0] w_px_y;
    logic [19:0] w_rd_addr;
    logic [19:0] w_wr_addr;
    logic        w_full;
    logic        w_in_range;
    logic        w_push;
    logic        w_pop;

`ifdef VGA_FB_DBUF_EN
    logic [31:0] r_frame;
    logic        r_swap_pend;
    logic        w_boundary;

    assign w_front_base = o_front_buf ? L_FB_SIZE : 20'd0;
    assign w_back_base  = o_front_buf ? 20'd0 : L_FB_SIZE;
    assign w_boundary   = (i_frame_counter != r_frame);

    // A request seen in a boundary cycle only arms the flag, so it lands one frame later.
    always_ff @(posedge i_clk) begin
        r_frame <= i_frame_counter;
        if (i_rst) begin
            o_front_buf <= 1'b0;
            o_swap_done <= 1'b0;
            r_swap_pend <= 1'b0;
        end else begin
            o_swap_done <= 1'b0;
            if (w_boundary && r_swap_pend) begin
                o_front_buf <= ~o_front_buf;
                o_swap_done <= 1'b1;
                r_swap_pend <= 1'b0;
            end else if (i_swap_req) begin
                r_swap_pend <= 1'b1;
            end
        end
    end
`else
    logic w_unused;

    assign w_unused     = ^{i_swap_req, i_frame_counter};
    assign w_front_base = 20'd0;
    assign w_back_base  = 20'd0;
    assign o_front_buf  = 1'b0;
    assign o_swap_done  = 1'b0;
`endif

    assign w_px_x     = ({8'd0, i_H_to_be_rendered} - 20'd1) >> SHIFT;
    assign w_px_y     = ({9'd0, i_V_to_be_rendered} - 20'd1) >> SHIFT;
    assign w_rd_addr  = w_front_base + w_px_y * L_FB_W + w_px_x;
    assign w_wr_addr  = w_back_base + {12'd0, i_wr_y} * L_FB_W + {11'd0, i_wr_x};

    assign w_full     = (r_count == (AW+1)'(WQ_DEPTH));
    assign o_wr_ready = ~w_full;
    assign w_in_range = ({11'd0, i_wr_x} < L_FB_W) && ({12'd0, i_wr_y} < L_FB_H);
    assign w_push     = i_wr_valid && ~w_full && w_in_range;
    assign w_pop      = ~i_to_be_rendered_valid && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_wq[r_wr_ptr] <= {w_wr_addr, i_wr_data};
        end
    end

    // Display requests take the SRAM unconditionally; the queue only drains in their gaps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_v2     <= 1'b0;
            o_mem_addr  <= 20'd0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= 16'd0;
            o_color     <= 24'd0;
        end else begin
            if (i_to_be_rendered_valid) begin
                r_state    <= S_READ;
                o_mem_addr <= w_rd_addr;
                o_mem_we   <= 1'b0;
            end else if (w_pop) begin
                r_state     <= S_WRITE;
                o_mem_addr  <= r_wq[r_rd_ptr][35:16];
                o_mem_wdata <= r_wq[r_rd_ptr][15:0];
                o_mem_we    <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else begin
                r_state  <= S_IDLE;
                o_mem_we <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

            r_rd_v2 <= (r_state == S_READ);
            o_color <= r_rd_v2 ? {i_mem_rdata[15:11], i_mem_rdata[15:13],
                                  i_mem_rdata[10:5],  i_mem_rdata[10:9],
                                  i_mem_rdata[4:0],   i_mem_rdata[4:2]} : 24'd0;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed test-plan steps then random traffic against a queue-based model.
module tb_vga_fb_arbiter;

    localparam int FB_W  = 400;
    localparam int FB_H  = 225;
    localparam int SHIFT = 2;
    localparam int QDEP  = 4;
`ifdef VGA_FB_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [11:0] hPos;
    logic [10:0] vPos;
    logic        reqValid;
    logic [31:0] frameCnt;
    logic [23:0] color;
    logic        wrValid;
    logic        wrReady;
    logic [8:0]  wrX;
    logic [7:0]  wrY;
    logic [15:0] wrData;
    logic        swapReq;
    logic        swapDone;
    logic        frontBuf;
    logic [19:0] memAddr;
    logic        memWe;
    logic [15:0] memWdata;
    logic [15:0] memRdata;

    logic [15:0] sram [0:262143];

    int passCnt = 0;
    int failCnt = 0;
    int totalCnt = 0;

    // Reference model state
    int          wqAddr[$];
    logic [15:0] wqData[$];
    bit          expWe;
    int          expWAddr;
    logic [15:0] expWData;
    bit          mReqValid;
    int          mReqAddr;
    logic [23:0] pend1, pipe2, colOut;
    bit          mFront, mPend, mDone;
    logic [31:0] mFrame;
    bit          justReset;

    vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .SHIFT(SHIFT), .WQ_DEPTH(QDEP)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_H_to_be_rendered(hPos), .i_V_to_be_rendered(vPos),
        .i_to_be_rendered_valid(reqValid), .i_frame_counter(frameCnt),
        .o_color(color),
        .i_wr_valid(wrValid), .o_wr_ready(wrReady),
        .i_wr_x(wrX), .i_wr_y(wrY), .i_wr_data(wrData),
        .i_swap_req(swapReq), .o_swap_done(swapDone), .o_front_buf(frontBuf),
        .o_mem_addr(memAddr), .o_mem_we(memWe), .o_mem_wdata(memWdata),
        .i_mem_rdata(memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        memRdata <= sram[memAddr[17:0]];
        if (memWe) sram[memAddr[17:0]] = memWdata;
    end

    function automatic logic [23:0] expand(input logic [15:0] d);
        int r = int'(d[15:11]);
        int g = int'(d[10:5]);
        int b = int'(d[4:0]);
        return 24'((((r << 3) | (r >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8) | ((b << 3) | (b >> 2)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge();
        int sizeBefore;
        int scale;
        int base;
        scale = 1 << SHIFT;
        if (rst) begin
            wqAddr.delete();
            wqData.delete();
            expWe = 0; mReqValid = 0;
            pend1 = 0; pipe2 = 0; colOut = 0;
            mFront = 0; mPend = 0; mDone = 0;
            mFrame = frameCnt;
            justReset = 1;
        end else begin
            justReset = 0;
            sizeBefore = wqAddr.size();
            colOut = pipe2;
            pipe2 = pend1;
            if (!reqValid && sizeBefore > 0) begin
                expWe = 1;
                expWAddr = wqAddr.pop_front();
                expWData = wqData.pop_front();
            end else begin
                expWe = 0;
            end
            mReqValid = reqValid;
            if (reqValid) begin
                base = mFront ? FB_W * FB_H : 0;
                mReqAddr = base + ((int'(vPos) - 1) / scale) * FB_W + (int'(hPos) - 1) / scale;
            end
            if (wrValid && sizeBefore < QDEP && int'(wrX) < FB_W && int'(wrY) < FB_H) begin
                base = (DBUF && !mFront) ? FB_W * FB_H : 0;
                wqAddr.push_back(base + int'(wrY) * FB_W + int'(wrX));
                wqData.push_back(wrData);
            end
            if (DBUF) begin
                if (frameCnt != mFrame && mPend) begin
                    mFront = !mFront;
                    mDone = 1;
                    mPend = 0;
                end else begin
                    mDone = 0;
                    if (swapReq) mPend = 1;
                end
            end
            mFrame = frameCnt;
        end
    endtask

    task automatic checkOutput();
        check("mem_we", memWe, expWe);
        if (expWe) begin
            check("wr_addr", memAddr, expWAddr);
            check("wr_data", memWdata, expWData);
        end
        if (mReqValid) check("rd_addr", memAddr, mReqAddr);
        if (justReset) begin
            check("rst_addr", memAddr, 0);
            check("rst_wdata", memWdata, 0);
        end
        check("color", color, colOut);
        check("wr_ready", wrReady, wqAddr.size() < QDEP);
        check("front_buf", frontBuf, mFront);
        check("swap_done", swapDone, mDone);
        pend1 = mReqValid ? expand(sram[mReqAddr]) : 24'd0;
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input bit v, input int h, input int vv, input bit wv,
                                 input int x, input int y, input logic [15:0] d, input bit sw);
        reqValid = v;
        hPos = 12'(h);
        vPos = 11'(vv);
        wrValid = wv;
        wrX = 9'(x);
        wrY = 8'(y);
        wrData = d;
        swapReq = sw;
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
        sram[0] = 16'hF800;
        sram[1] = 16'h001F;
        sram[400] = 16'h07E0;
        sram[90000] = 16'hFFFF;
        frameCnt = 32'd5;
        rst = 1'b1;
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        cycle();
        check("rst_ready", wrReady, 1);
        check("rst_color", color, 0);
        rst = 1'b0;

        // Red pixel at (1,1), three cycles of latency.
        applyStimulus(1, 1, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        cycle();
        check("tp_red", color, 24'hFF0000);

        applyStimulus(1, 4, 4, 0, 0, 0, 16'h0, 0);
        cycle();
        check("tp_addr44", memAddr, 0);
        applyStimulus(1, 5, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        check("tp_addr51", memAddr, 1);
        applyStimulus(1, 1, 5, 0, 0, 0, 16'h0, 0);
        cycle();
        check("tp_addr15", memAddr, 400);
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Full active line with writes offered at its start.
        for (int i = 0; i < 1600; i++) begin
            applyStimulus(1, i + 1, 10, i < 6, i, 3, 16'($urandom), 0);
            cycle();
        end
        check("tp_line_ready", wrReady, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("tp_drain_we", memWe, 1);
        end
        cycle();
        check("tp_drain_done", memWe, 0);

        // Corner pixel write, then an out-of-range write that must be dropped.
        applyStimulus(0, 1, 1, 1, 399, 224, 16'h07E0, 0);
        cycle();
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        check("tp_corner_we", memWe, 1);
        check("tp_corner_addr", memAddr, DBUF ? 179999 : 89999);
        applyStimulus(0, 1, 1, 1, 400, 0, 16'h1234, 0);
        cycle();
        check("tp_oob_ready", wrReady, 1);
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        check("tp_oob_we", memWe, 0);

        // Mid-frame swap request, taken at the 5->6 boundary.
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 1);
        cycle();
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        check("tp_swap_wait", swapDone, 0);
        frameCnt = 32'd6;
        cycle();
        check("tp_swap_front", frontBuf, DBUF);
        check("tp_swap_pulse", swapDone, DBUF);
        cycle();
        check("tp_swap_single", swapDone, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        check("tp_swap_rdaddr", memAddr, DBUF ? 90000 : 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Reset with writes queued and a swap pending.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 1, 10 + i, 5, 16'hABCD, i == 2);
            cycle();
        end
        rst = 1'b1;
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        check("tp_rst_we", memWe, 0);
        check("tp_rst_ready", wrReady, 1);
        check("tp_rst_front", frontBuf, 0);
        rst = 1'b0;
        frameCnt = 32'd7;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("tp_rst_nowrite", memWe, 0);
            check("tp_rst_noswap", swapDone, 0);
        end

        // Request in the boundary cycle itself waits for the next boundary.
        frameCnt = 32'd8;
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 1);
        cycle();
        check("tp_bnd_defer", swapDone, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0, 0);
        cycle();
        frameCnt = 32'd9;
        cycle();
        check("tp_bnd_apply", swapDone, DBUF);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) frameCnt = frameCnt + 1;
            rst = ($urandom_range(0, 399) == 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(1, 1600), $urandom_range(1, 900),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 410), $urandom_range(0, 230),
                          16'($urandom), $urandom_range(0, 19) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
